// File: rtl/ebus_pkg.sv
// Shared types and constants for the ebus arbiter and its clients.
// Holds the arbiter state encoding and the idle strobe pattern.
package ebus_pkg;

   typedef enum logic [2:0] {
      ST_CPU,
      ST_REQ,
      ST_GRANT,
      ST_DRAIN,
      ST_REL,
      ST_ABORT
   } state_t;

   typedef struct packed {
      logic rd_n;
      logic wr_n;
      logic mreq_n;
      logic iorq_n;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = 4'b1111;

   localparam int ACK_TIMEOUT_DEF  = 64;
   localparam int DRAIN_CYCLES_DEF = 2;

endpackage

// File: rtl/phi_edge.sv
// Edge detector for the CPU clock phi, sampled in the clk domain.
// Reusable by any ebus client that has to act on phi edges.
module phi_edge (
   input  logic clk,
   input  logic reset,
   input  logic phi,
   output logic phi_fall,
   output logic phi_rise
);

   logic phi_r_q;
   logic phi_r_d;

   always_comb begin
      phi_r_d = phi;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phi_r_q <= 1'b0;
      end else begin
         phi_r_q <= phi_r_d;
      end
   end

   assign phi_fall = phi_r_q & ~phi;
   assign phi_rise = ~phi_r_q & phi;

endmodule

// File: rtl/ebus_arbiter.sv
// Hands the Z80 expansion bus between the external CPU and the SPI bus
// master using the BUSREQ/BUSACK handshake, stepping on phi falling edges.
module ebus_arbiter
   import ebus_pkg::*;
#(
   parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ebus_phi,
   input  logic        ebus_busack_n,
   output logic        ebus_busreq_n,
   output logic        ebus_oe,
   output logic [15:0] ebus_a,
   output logic [7:0]  ebus_wrdata,
   output logic        ebus_wrdata_en,
   output logic        ebus_rd_n,
   output logic        ebus_wr_n,
   output logic        ebus_mreq_n,
   output logic        ebus_iorq_n,
   input  logic        spibm_busreq,
   input  logic [15:0] spibm_a,
   input  logic [7:0]  spibm_wrdata,
   input  logic        spibm_wrdata_en,
   input  logic        spibm_rd_n,
   input  logic        spibm_wr_n,
   input  logic        spibm_mreq_n,
   input  logic        spibm_iorq_n,
   output logic        spibm_granted,
   output logic        ack_timeout
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [DW-1:0] DRN_LAST = DW'(DRAIN_CYCLES - 1);

   logic phi_fall;
   logic phi_rise_unused;

   phi_edge u_phi_edge (
      .clk      (clk),
      .reset    (reset),
      .phi      (ebus_phi),
      .phi_fall (phi_fall),
      .phi_rise (phi_rise_unused)
   );

   state_t        state_q, state_d;
   logic          busreq_n_q, busreq_n_d;
   logic          oe_q, oe_d;
   logic          granted_q, granted_d;
   logic          ack_timeout_q, ack_timeout_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [DW-1:0] drn_cnt_q, drn_cnt_d;
   logic [15:0]   a_q, a_d;
   logic [7:0]    wrdata_q, wrdata_d;
   logic          wrdata_en_q, wrdata_en_d;
   strobe_t       strb_q, strb_d;
   strobe_t       spibm_strb;
   logic          grant_nxt;

   assign spibm_strb = '{
      rd_n:   spibm_rd_n,
      wr_n:   spibm_wr_n,
      mreq_n: spibm_mreq_n,
      iorq_n: spibm_iorq_n
   };

   always_comb begin
      state_d       = state_q;
      busreq_n_d    = busreq_n_q;
      oe_d          = oe_q;
      granted_d     = granted_q;
      ack_timeout_d = ack_timeout_q;
      tmo_cnt_d     = tmo_cnt_q;
      drn_cnt_d     = drn_cnt_q;
      if (phi_fall) begin
         unique case (state_q)
            ST_CPU: begin
               if (spibm_busreq) begin
                  state_d    = ST_REQ;
                  busreq_n_d = 1'b0;
                  tmo_cnt_d  = '0;
               end
            end
            ST_REQ: begin
               // withdrawal beats ACK, ACK beats the timeout
               if (!spibm_busreq) begin
                  state_d    = ST_CPU;
                  busreq_n_d = 1'b1;
               end else if (!ebus_busack_n) begin
                  state_d       = ST_GRANT;
                  granted_d     = 1'b1;
                  oe_d          = 1'b1;
                  ack_timeout_d = 1'b0;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  state_d       = ST_ABORT;
                  ack_timeout_d = 1'b1;
                  busreq_n_d    = 1'b1;
               end else if (tmo_cnt_q != '1) begin
                  tmo_cnt_d = tmo_cnt_q + TW'(1);
               end
            end
            ST_GRANT: begin
               if (!spibm_busreq) begin
                  state_d   = ST_DRAIN;
                  drn_cnt_d = '0;
               end
            end
            ST_DRAIN: begin
               if (drn_cnt_q == DRN_LAST) begin
                  state_d    = ST_REL;
                  busreq_n_d = 1'b1;
                  oe_d       = 1'b0;
                  granted_d  = 1'b0;
               end else if (drn_cnt_q != '1) begin
                  drn_cnt_d = drn_cnt_q + DW'(1);
               end
            end
            ST_REL: begin
               if (ebus_busack_n) begin
                  state_d = ST_CPU;
               end
            end
            ST_ABORT: begin
               if (!spibm_busreq) begin
                  state_d = ST_CPU;
               end
            end
            default: begin
               state_d = ST_CPU;
            end
         endcase
      end
   end

   // Pins follow spibm only while granted; idle strobes from the hand-over edge on
   always_comb begin
      grant_nxt   = (state_d == ST_GRANT);
      a_d         = a_q;
      wrdata_d    = wrdata_q;
      wrdata_en_d = 1'b0;
      strb_d      = STROBE_IDLE;
      if (grant_nxt) begin
         a_d         = spibm_a;
         wrdata_d    = spibm_wrdata;
         wrdata_en_d = spibm_wrdata_en;
         strb_d      = spibm_strb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_CPU;
         busreq_n_q    <= 1'b1;
         oe_q          <= 1'b0;
         granted_q     <= 1'b0;
         ack_timeout_q <= 1'b0;
         tmo_cnt_q     <= '0;
         drn_cnt_q     <= '0;
         a_q           <= '0;
         wrdata_q      <= '0;
         wrdata_en_q   <= 1'b0;
         strb_q        <= STROBE_IDLE;
      end else begin
         state_q       <= state_d;
         busreq_n_q    <= busreq_n_d;
         oe_q          <= oe_d;
         granted_q     <= granted_d;
         ack_timeout_q <= ack_timeout_d;
         tmo_cnt_q     <= tmo_cnt_d;
         drn_cnt_q     <= drn_cnt_d;
         a_q           <= a_d;
         wrdata_q      <= wrdata_d;
         wrdata_en_q   <= wrdata_en_d;
         strb_q        <= strb_d;
      end
   end

   assign ebus_busreq_n  = busreq_n_q;
   assign ebus_oe        = oe_q;
   assign ebus_a         = a_q;
   assign ebus_wrdata    = wrdata_q;
   assign ebus_wrdata_en = wrdata_en_q;
   assign ebus_rd_n      = strb_q.rd_n;
   assign ebus_wr_n      = strb_q.wr_n;
   assign ebus_mreq_n    = strb_q.mreq_n;
   assign ebus_iorq_n    = strb_q.iorq_n;
   assign spibm_granted  = granted_q;
   assign ack_timeout    = ack_timeout_q;

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter: vector table, corner sequences
// and a randomized run against a phi-event-level reference model.
module tb_ebus_arbiter;

   localparam int TMO = 64;
   localparam int DRN = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ebus_phi;
   logic        ebus_busack_n;
   logic        ebus_busreq_n;
   logic        ebus_oe;
   logic [15:0] ebus_a;
   logic [7:0]  ebus_wrdata;
   logic        ebus_wrdata_en;
   logic        ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n;
   logic        spibm_busreq;
   logic [15:0] spibm_a;
   logic [7:0]  spibm_wrdata;
   logic        spibm_wrdata_en;
   logic        spibm_rd_n, spibm_wr_n, spibm_mreq_n, spibm_iorq_n;
   logic        spibm_granted;
   logic        ack_timeout;

   ebus_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .ebus_phi        (ebus_phi),
      .ebus_busack_n   (ebus_busack_n),
      .ebus_busreq_n   (ebus_busreq_n),
      .ebus_oe         (ebus_oe),
      .ebus_a          (ebus_a),
      .ebus_wrdata     (ebus_wrdata),
      .ebus_wrdata_en  (ebus_wrdata_en),
      .ebus_rd_n       (ebus_rd_n),
      .ebus_wr_n       (ebus_wr_n),
      .ebus_mreq_n     (ebus_mreq_n),
      .ebus_iorq_n     (ebus_iorq_n),
      .spibm_busreq    (spibm_busreq),
      .spibm_a         (spibm_a),
      .spibm_wrdata    (spibm_wrdata),
      .spibm_wrdata_en (spibm_wrdata_en),
      .spibm_rd_n      (spibm_rd_n),
      .spibm_wr_n      (spibm_wr_n),
      .spibm_mreq_n    (spibm_mreq_n),
      .spibm_iorq_n    (spibm_iorq_n),
      .spibm_granted   (spibm_granted),
      .ack_timeout     (ack_timeout)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: who owns the bus, advanced once per phi fall
   typedef enum int {M_IDLE, M_ASK, M_OWN, M_FLUSH, M_GIVEBACK, M_LOCKOUT} mode_t;
   mode_t       mode;
   int          age, drain_left;
   bit          m_prev_phi, m_tmo, m_wden;
   logic [15:0] m_a;
   logic [7:0]  m_wd;
   logic [3:0]  m_strb;

   task automatic model_edge();
      bit fall;
      if (reset) begin
         mode = M_IDLE; age = 0; drain_left = 0; m_prev_phi = 0;
         m_tmo = 0; m_wden = 0; m_a = '0; m_wd = '0; m_strb = 4'hF;
         return;
      end
      fall = m_prev_phi && !ebus_phi;
      m_prev_phi = ebus_phi;
      if (fall) begin
         case (mode)
            M_IDLE: if (spibm_busreq) begin mode = M_ASK; age = 0; end
            M_ASK: begin
               age++;
               if (!spibm_busreq) mode = M_IDLE;
               else if (!ebus_busack_n) begin mode = M_OWN; m_tmo = 0; end
               else if (age >= TMO) begin mode = M_LOCKOUT; m_tmo = 1; end
            end
            M_OWN: if (!spibm_busreq) begin mode = M_FLUSH; drain_left = DRN; end
            M_FLUSH: begin
               drain_left--;
               if (drain_left == 0) mode = M_GIVEBACK;
            end
            M_GIVEBACK: if (ebus_busack_n) mode = M_IDLE;
            M_LOCKOUT: if (!spibm_busreq) mode = M_IDLE;
            default: mode = M_IDLE;
         endcase
      end
      if (mode == M_OWN) begin
         m_a = spibm_a; m_wd = spibm_wrdata; m_wden = spibm_wrdata_en;
         m_strb = {spibm_rd_n, spibm_wr_n, spibm_mreq_n, spibm_iorq_n};
      end else begin
         m_strb = 4'hF; m_wden = 0;
      end
   endtask

   function automatic logic [3:0] strobes();
      return {ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n};
   endfunction

   task automatic step();
      bit holds;
      @(posedge clk);
      model_edge();
      #1;
      holds = (mode == M_OWN) || (mode == M_FLUSH);
      chk("busreq_n", ebus_busreq_n, !(holds || mode == M_ASK));
      chk("oe", ebus_oe, holds);
      chk("granted", spibm_granted, holds);
      chk("ack_timeout", ack_timeout, m_tmo);
      chk("strobes", strobes(), m_strb);
      chk("wrdata_en", ebus_wrdata_en, m_wden);
      chk("addr", ebus_a, m_a);
      chk("wrdata", ebus_wrdata, m_wd);
   endtask

   task automatic phi_cyc();
      ebus_phi = 1'b1; step(); step();
      ebus_phi = 1'b0; step(); step();
   endtask

   task automatic set_strb(input logic [3:0] s);
      {spibm_rd_n, spibm_wr_n, spibm_mreq_n, spibm_iorq_n} = s;
   endtask

   typedef struct {
      logic        req;
      logic        ack_n;
      logic [3:0]  strb;
      logic [15:0] a;
      logic [7:0]  wd;
      logic        wden;
      logic        e_busreq_n;
      logic        e_oe;
      logic        e_g;
      logic [3:0]  e_strb;
      logic [15:0] e_a;
      logic        e_wden;
   } vec_t;

   vec_t vt[13];

   initial begin
      int k;
      reset = 1'b1; ebus_phi = 1'b0; ebus_busack_n = 1'b1;
      spibm_busreq = 1'b0; spibm_a = '0; spibm_wrdata = '0;
      spibm_wrdata_en = 1'b0; set_strb(4'hF);

      // strobe order {rd_n, wr_n, mreq_n, iorq_n}
      vt[0]  = '{0, 1, 4'hF, 16'h0000, 8'h00, 0, 1, 0, 0, 4'hF, 16'h0000, 0};
      vt[1]  = '{1, 1, 4'hF, 16'h0000, 8'h00, 0, 0, 0, 0, 4'hF, 16'h0000, 0};
      vt[2]  = '{1, 1, 4'hF, 16'h0000, 8'h00, 0, 0, 0, 0, 4'hF, 16'h0000, 0};
      vt[3]  = '{1, 0, 4'h5, 16'h3000, 8'h00, 0, 0, 1, 1, 4'h5, 16'h3000, 0};
      vt[4]  = '{1, 0, 4'h9, 16'h3001, 8'hA5, 1, 0, 1, 1, 4'h9, 16'h3001, 1};
      vt[5]  = '{0, 0, 4'h9, 16'h3001, 8'hA5, 1, 0, 1, 1, 4'hF, 16'h3001, 0};
      vt[6]  = '{0, 0, 4'h9, 16'h4000, 8'hA5, 1, 0, 1, 1, 4'hF, 16'h3001, 0};
      vt[7]  = '{0, 0, 4'h9, 16'h4000, 8'hA5, 1, 1, 0, 0, 4'hF, 16'h3001, 0};
      vt[8]  = '{1, 0, 4'h9, 16'h4000, 8'hA5, 1, 1, 0, 0, 4'hF, 16'h3001, 0};
      vt[9]  = '{1, 1, 4'hF, 16'h4000, 8'hA5, 0, 1, 0, 0, 4'hF, 16'h3001, 0};
      vt[10] = '{1, 1, 4'hF, 16'h4000, 8'hA5, 0, 0, 0, 0, 4'hF, 16'h3001, 0};
      vt[11] = '{0, 1, 4'hF, 16'h4000, 8'hA5, 0, 1, 0, 0, 4'hF, 16'h3001, 0};
      vt[12] = '{0, 1, 4'h6, 16'h5555, 8'h5A, 1, 1, 0, 0, 4'hF, 16'h3001, 0};

      step();
      reset = 1'b0;
      chk("reset_busreq_n", ebus_busreq_n, 1'b1);
      chk("reset_strobes", strobes(), 4'hF);
      chk("reset_addr", ebus_a, 16'h0000);

      for (int i = 0; i < 13; i++) begin
         spibm_busreq = vt[i].req; ebus_busack_n = vt[i].ack_n;
         set_strb(vt[i].strb); spibm_a = vt[i].a;
         spibm_wrdata = vt[i].wd; spibm_wrdata_en = vt[i].wden;
         phi_cyc();
         chk($sformatf("vec%0d_busreq_n", i), ebus_busreq_n, vt[i].e_busreq_n);
         chk($sformatf("vec%0d_oe", i), ebus_oe, vt[i].e_oe);
         chk($sformatf("vec%0d_granted", i), spibm_granted, vt[i].e_g);
         chk($sformatf("vec%0d_strobes", i), strobes(), vt[i].e_strb);
         chk($sformatf("vec%0d_addr", i), ebus_a, vt[i].e_a);
         chk($sformatf("vec%0d_wrdata_en", i), ebus_wrdata_en, vt[i].e_wden);
         chk($sformatf("vec%0d_ack_timeout", i), ack_timeout, 1'b0);
      end

      // Timeout: abort on the 64th fall after the request fall
      set_strb(4'hF); spibm_wrdata_en = 1'b0;
      spibm_busreq = 1'b1; ebus_busack_n = 1'b1;
      phi_cyc();
      k = 1;
      while (k <= 80) begin
         phi_cyc();
         if (ebus_busreq_n) break;
         k++;
      end
      chk("timeout_fall", k, TMO);
      chk("timeout_flag", ack_timeout, 1'b1);
      repeat (3) phi_cyc();
      chk("abort_ignores_req", ebus_busreq_n, 1'b1);
      spibm_busreq = 1'b0; phi_cyc();
      chk("timeout_sticky", ack_timeout, 1'b1);

      // ACK on the same fall as the timeout: grant wins
      spibm_busreq = 1'b1; phi_cyc();
      for (int j = 1; j <= TMO; j++) begin
         ebus_busack_n = (j == TMO) ? 1'b0 : 1'b1;
         phi_cyc();
      end
      chk("ack_vs_tmo_granted", spibm_granted, 1'b1);
      chk("ack_vs_tmo_flag", ack_timeout, 1'b0);

      // Reset while granted with a live memory read
      spibm_a = 16'h3000; set_strb(4'h5);
      step(); step();
      chk("grant_mreq", ebus_mreq_n, 1'b0);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst_grant_busreq_n", ebus_busreq_n, 1'b1);
      chk("rst_grant_oe", ebus_oe, 1'b0);
      chk("rst_grant_granted", spibm_granted, 1'b0);
      chk("rst_grant_strobes", strobes(), 4'hF);

      // ACK on the same fall as the request drop: drop wins
      ebus_busack_n = 1'b1; set_strb(4'hF);
      spibm_busreq = 1'b1; phi_cyc();
      spibm_busreq = 1'b0; ebus_busack_n = 1'b0; phi_cyc();
      chk("drop_vs_ack_busreq_n", ebus_busreq_n, 1'b1);
      chk("drop_vs_ack_granted", spibm_granted, 1'b0);
      ebus_busack_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 2) == 0) ebus_phi = ~ebus_phi;
         if ($urandom_range(0, 39) == 0) spibm_busreq = ~spibm_busreq;
         if ($urandom_range(0, 9) == 0) ebus_busack_n = ~ebus_busack_n;
         set_strb(4'($urandom));
         spibm_a = 16'($urandom);
         spibm_wrdata = 8'($urandom);
         spibm_wrdata_en = 1'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
